// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with saturating-counter
// direction prediction, mispredict detection and saturating statistics.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush             invalidate every entry (counters/targets/stats kept)
//   pc_if             fetch PC used for the combinational lookup
//   pred_hit          valid entry with matching tag at pc_if
//   pred_taken        pred_hit and counter MSB set
//   pred_next_pc      predicted fetch PC (stored target or pc_if+4)
//   upd_*             resolved branch from MEM used for training
//   mispredict        resolved next PC differs from the one predicted
//   redirect_pc       resolved next PC
//   branch_cnt        saturating count of accepted updates
//   mispred_cnt       saturating count of mispredicts
module branch_predictor #(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_next_pc,
    input  logic                  upd_en,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_next_pc,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [STAT_WIDTH-1:0] branch_cnt,
    output logic [STAT_WIDTH-1:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [CNT_WIDTH-1:0]  cnt_q    [ENTRIES];

    logic [STAT_WIDTH-1:0] branch_cnt_q;
    logic [STAT_WIDTH-1:0] mispred_cnt_q;

    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic [IDX_W-1:0]      up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_hit;
    logic [ADDR_WIDTH-1:0] actual_next_pc;

    // The predicted direction is already folded into upd_pred_next_pc.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    // Combinational lookup against the registered table (old contents on a
    // same-cycle update).
    always_comb begin
        lk_idx       = pc_if[IDX_W+1:2];
        lk_tag       = pc_if[ADDR_WIDTH-1:IDX_W+2];
        pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken   = pred_hit && cnt_q[lk_idx][CNT_WIDTH-1];
        pred_next_pc = pred_taken ? target_q[lk_idx] : (pc_if + PC_STEP);
    end

    // Resolution check; wrong direction and wrong target both show up as a
    // next-PC mismatch.
    always_comb begin
        up_idx         = upd_pc[IDX_W+1:2];
        up_tag         = upd_pc[ADDR_WIDTH-1:IDX_W+2];
        up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        actual_next_pc = upd_taken ? upd_target : (upd_pc + PC_STEP);
        redirect_pc    = actual_next_pc;
        mispredict     = upd_en && (actual_next_pc != upd_pred_next_pc);
    end

    // Table training; flush beats update, reset beats both.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                    if (cnt_q[up_idx] != CNT_MAX) begin
                        cnt_q[up_idx] <= cnt_q[up_idx] + CNT_WIDTH'(1);
                    end
                end else if (cnt_q[up_idx] != '0) begin
                    cnt_q[up_idx] <= cnt_q[up_idx] - CNT_WIDTH'(1);
                end
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                cnt_q[up_idx]    <= CNT_WEAK;
            end
        end
    end

    // Statistics keep counting through a flush; they stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (upd_en && (branch_cnt_q != STAT_MAX)) begin
                branch_cnt_q <= branch_cnt_q + STAT_WIDTH'(1);
            end
            if (mispredict && (mispred_cnt_q != STAT_MAX)) begin
                mispred_cnt_q <= mispred_cnt_q + STAT_WIDTH'(1);
            end
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a reference table model produces the
// expected outputs of every driven cycle; a monitor pops and compares them.
// A second instance with 3-bit statistics shows counter saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst, flush, upd_en, upd_taken, upd_pred_taken;
    logic [31:0] pc_if, upd_pc, upd_target, upd_pred_next_pc;

    logic        pred_hit, pred_taken, mispredict;
    logic [31:0] pred_next_pc, redirect_pc, branch_cnt, mispred_cnt;

    logic        s_hit, s_taken, s_misp;
    logic [31:0] s_npc, s_rpc;
    logic [2:0]  s_bcnt, s_mcnt;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .ADDR_WIDTH(32), .CNT_WIDTH(2), .STAT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pc_if(pc_if),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_predictor #(.ENTRIES(16), .ADDR_WIDTH(32), .CNT_WIDTH(2), .STAT_WIDTH(3)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .pc_if(pc_if),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_next_pc(s_npc),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
        .mispredict(s_misp), .redirect_pc(s_rpc),
        .branch_cnt(s_bcnt), .mispred_cnt(s_mcnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] npc;
        logic        misp;
        logic [31:0] rpc;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
        logic [31:0] sbcnt;
        logic [31:0] smcnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t got_e;

    // Reference table model
    logic [15:0] m_valid;
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_cnt [16];
    int          m_bcnt, m_mcnt;

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
    endfunction

    function automatic logic [31:0] m_pred(input logic [31:0] pc);
        if (m_hit(pc) && m_cnt[pc[5:2]] >= 2) return m_tgt[pc[5:2]];
        return pc + 32'd4;
    endfunction

    task automatic m_reset();
        m_valid = '0;
        for (int i = 0; i < 16; i++) begin
            m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
        end
        m_bcnt = 0; m_mcnt = 0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            got_e = sb_q.pop_front();
            chk("pred_hit",     32'(pred_hit),     32'(got_e.hit));
            chk("pred_taken",   32'(pred_taken),   32'(got_e.taken));
            chk("pred_next_pc", pred_next_pc,      got_e.npc);
            chk("mispredict",   32'(mispredict),   32'(got_e.misp));
            chk("redirect_pc",  redirect_pc,       got_e.rpc);
            chk("branch_cnt",   branch_cnt,        got_e.bcnt);
            chk("mispred_cnt",  mispred_cnt,       got_e.mcnt);
            chk("s_next_pc",    s_npc,             got_e.npc);
            chk("s_branch_cnt", 32'(s_bcnt),       got_e.sbcnt);
            chk("s_mispred_cnt", 32'(s_mcnt),      got_e.smcnt);
        end
    end

    // One cycle: drive, push expectation, let the monitor compare, advance model.
    task automatic step(input logic r, input logic f, input logic [31:0] pc,
                        input logic en, input logic [31:0] upc, input logic tk,
                        input logic [31:0] tg, input logic [31:0] pn);
        exp_t        e;
        logic [31:0] actual;
        logic [3:0]  ui;
        @(posedge clk);
        #1;
        rst = r; flush = f; pc_if = pc; upd_en = en; upd_pc = upc;
        upd_taken = tk; upd_target = tg; upd_pred_next_pc = pn;
        upd_pred_taken = (pn != upc + 32'd4);
        actual  = tk ? tg : upc + 32'd4;
        e.hit   = m_hit(pc);
        e.taken = m_hit(pc) && (m_cnt[pc[5:2]] >= 2);
        e.npc   = m_pred(pc);
        e.misp  = en && (actual != pn);
        e.rpc   = actual;
        e.bcnt  = 32'(m_bcnt);
        e.mcnt  = 32'(m_mcnt);
        e.sbcnt = 32'(sat7(m_bcnt));
        e.smcnt = 32'(sat7(m_mcnt));
        sb_q.push_back(e);
        @(negedge clk);
        #1;
        ui = upc[5:2];
        if (r) begin
            m_reset();
        end else begin
            if (f) begin
                m_valid = '0;
            end else if (en) begin
                if (m_hit(upc)) begin
                    if (tk) begin
                        m_tgt[ui] = tg;
                        if (m_cnt[ui] < 3) m_cnt[ui]++;
                    end else if (m_cnt[ui] > 0) begin
                        m_cnt[ui]--;
                    end
                end else if (tk) begin
                    m_valid[ui] = 1'b1; m_tag[ui] = upc[31:6];
                    m_tgt[ui] = tg; m_cnt[ui] = 2;
                end
            end
            if (en) m_bcnt++;
            if (e.misp) m_mcnt++;
        end
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b0, 1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input logic tk,
                       input logic [31:0] tg, input logic [31:0] pn);
        step(1'b0, 1'b0, pc, 1'b1, upc, tk, tg, pn);
    endtask

    logic [31:0] pcs [5];

    initial begin
        pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'hC0;
        pcs[3] = 32'h44; pcs[4] = 32'h1040;
        rst = 1'b1; flush = 1'b0; pc_if = 32'h0; upd_en = 1'b0; upd_pc = 32'h0;
        upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0;
        upd_pred_next_pc = 32'h0;
        repeat (2) @(posedge clk);
        m_reset();

        // Reset state lookup
        look(32'h40);
        chk("tp1_hit", 32'(pred_hit), 32'd0);
        chk("tp1_npc", pred_next_pc, 32'h44);
        chk("tp1_bcnt", branch_cnt, 32'd0);

        // First taken update allocates and mispredicts
        upd(32'h40, 32'h40, 1'b1, 32'h100, 32'h44);
        chk("tp2_misp", 32'(mispredict), 32'd1);
        chk("tp2_rpc", redirect_pc, 32'h100);
        look(32'h40);
        chk("tp2_npc", pred_next_pc, 32'h100);
        chk("tp2_mcnt", mispred_cnt, 32'd1);

        // Counter walk down, up and saturation
        upd(32'h40, 32'h40, 1'b0, 32'h100, 32'h100);
        upd(32'h40, 32'h40, 1'b0, 32'h100, 32'h44);
        look(32'h40);
        chk("tp3_npc_nt", pred_next_pc, 32'h44);
        upd(32'h40, 32'h40, 1'b1, 32'h100, 32'h44);
        look(32'h40);
        chk("tp3_npc_weak", pred_next_pc, 32'h44);
        repeat (4) upd(32'h40, 32'h40, 1'b1, 32'h100, 32'h44);
        upd(32'h40, 32'h40, 1'b0, 32'h100, 32'h100);
        look(32'h40);
        chk("tp3_sat", pred_next_pc, 32'h100);

        // Alias at index 0 overwrites the entry
        upd(32'h40, 32'h80, 1'b1, 32'h200, 32'h84);
        look(32'h40);
        chk("tp4_miss", 32'(pred_hit), 32'd0);
        look(32'h80);
        chk("tp4_npc", pred_next_pc, 32'h200);
        upd(32'h80, 32'h80, 1'b0, 32'h200, 32'h200);
        look(32'h80);
        chk("tp4_cnt2", pred_next_pc, 32'h84);

        // Same-cycle lookup/update sees old contents
        upd(32'h40, 32'h40, 1'b1, 32'h300, 32'h44);
        upd(32'h40, 32'h40, 1'b0, 32'h300, 32'h44);
        chk("tp5_old", pred_next_pc, 32'h300);
        chk("tp5_nomisp", 32'(mispredict), 32'd0);
        look(32'h40);
        chk("tp5_new", pred_next_pc, 32'h44);
        upd(32'h40, 32'h40, 1'b1, 32'h400, 32'h300);
        chk("tp5_tgt_misp", 32'(mispredict), 32'd1);

        // Flush with update: table drops it, statistics count it
        upd(32'h40, 32'h40, 1'b1, 32'h300, 32'h300);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h500, 32'h44);
        look(32'h40);
        chk("tp6_flush40", 32'(pred_hit), 32'd0);
        look(32'h80);
        chk("tp6_flush80", 32'(pred_hit), 32'd0);

        // Mixed random traffic
        for (int i = 0; i < 30; i++) begin
            logic [31:0] p, u, t, n;
            p = pcs[$urandom_range(0, 4)];
            u = pcs[$urandom_range(0, 4)];
            t = 32'($urandom_range(1, 255)) << 2;
            n = ($urandom_range(0, 1) == 1) ? m_pred(u) : t;
            if ($urandom_range(0, 3) == 0) look(p);
            else upd(p, u, 1'($urandom_range(0, 1)), t, n);
        end

        // Reset mid-sequence with a pending update
        step(1'b1, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h600, 32'h44);
        look(32'h40);
        chk("rst_hit", 32'(pred_hit), 32'd0);
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", mispred_cnt, 32'd0);

        for (int i = 0; i < 12; i++) upd(32'h80, 32'h80, 1'b1, 32'h700, 32'h84);
        look(32'h80);
        chk("sat_sbcnt", 32'(s_bcnt), 32'd7);
        chk("sat_bcnt", branch_cnt, 32'd12);

        @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direct-mapped branch target buffer with saturating-counter direction prediction for the 5-stage MIPS pipeline. It sits beside the IF stage and lets the fetch PC redirect speculatively in the same cycle, instead of always fetching PC+4 until the branch resolves in MEM. The MEM stage feeds back resolved branch outcomes to train the table. The block also reports mispredict/redirect information and keeps saturating performance counters.

## Interface
Parameters:
- `ENTRIES`, 16: number of BTB entries; power of two, ≥2. `IDX_W` = log2(`ENTRIES`).
- `ADDR_WIDTH`, 32: PC width. Tag = `pc[ADDR_WIDTH-1:IDX_W+2]`, index = `pc[IDX_W+1:2]`.
- `CNT_WIDTH`, 2: direction counter width, ≥1.
- `STAT_WIDTH`, 32: performance counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: invalidate all entries; counters and statistics are kept.
- `pc_if` in ADDR_WIDTH: current fetch PC.
- `pred_hit` out 1: valid entry with matching tag.
- `pred_taken` out 1: `pred_hit` & counter MSB.
- `pred_next_pc` out ADDR_WIDTH: `pred_taken` ? stored target : `pc_if`+4.
- `upd_en` in 1: resolved branch/jump present in MEM this cycle.
- `upd_pc` in ADDR_WIDTH: PC of the resolved instruction.
- `upd_taken` in 1: actual outcome.
- `upd_target` in ADDR_WIDTH: actual taken target.
- `upd_pred_taken` in 1: prediction carried down the pipe with the instruction.
- `upd_pred_next_pc` in ADDR_WIDTH: predicted next PC carried down the pipe.
- `mispredict` out 1: redirect required.
- `redirect_pc` out ADDR_WIDTH: correct next PC.
- `branch_cnt` out STAT_WIDTH: number of accepted updates.
- `mispred_cnt` out STAT_WIDTH: number of mispredicts.

## Operation
- Table state per entry: `valid`, tag, target (ADDR_WIDTH), counter (CNT_WIDTH).
- Lookup is purely combinational from `pc_if` and the registered table.
- Actual next PC = `upd_taken` ? `upd_target` : `upd_pc`+4, computed modulo 2^ADDR_WIDTH. `redirect_pc` always shows this value; it is only meaningful when `mispredict`=1.
- `mispredict` = `upd_en` & (actual next PC != `upd_pred_next_pc`). This covers a wrong direction and a wrong target alike.
- Training, applied on a clock edge with `upd_en`=1:
  - Hit and taken: counter increments, saturating at 2^CNT_WIDTH−1; target ← `upd_target`.
  - Hit and not taken: counter decrements, saturating at 0; target unchanged.
  - Miss and taken: allocate the entry. `valid`←1, tag written, target ← `upd_target`, counter ← 2^(CNT_WIDTH−1) (weakly taken). Any aliasing entry is overwritten.
  - Miss and not taken: no table change.
- Statistics: `branch_cnt` increments on every `upd_en`; `mispred_cnt` increments when `mispredict`=1. Both saturate at all-ones.
- Priority: `rst` > `flush` > update.
  - `flush` together with `upd_en`: all valid bits clear and the update is dropped from the table, but statistics still count it.
  - `rst` with `upd_en`: everything is cleared; nothing is counted.

## Timing
- Lookup latency is 0 cycles: `pred_*` follow `pc_if` in the same cycle.
- An update becomes visible to lookup on the cycle after the `upd_en` edge. A lookup and an update to the same index in the same cycle return the old (pre-update) contents.
- `mispredict` and `redirect_pc` are combinational from the `upd_*` inputs, with no added latency.
- Reset values, one cycle after `rst`:
  - all `valid`=0, all counters 0, tags and targets 0;
  - `branch_cnt`=`mispred_cnt`=0;
  - hence `pred_hit`=0, `pred_taken`=0, `pred_next_pc`=`pc_if`+4.
  - `mispredict` and `redirect_pc` remain combinational from the inputs.
- `flush` takes effect in 1 cycle for all entries.
- There is no stall input. The caller holds `upd_en`=0 for bubbles and squashed instructions.

## Test plan
Defaults: ENTRIES=16, CNT_WIDTH=2.
1. Reset, then `pc_if`=0x40 → `pred_hit`=0, `pred_taken`=0, `pred_next_pc`=0x44; both statistics counters 0.
2. Update `upd_pc`=0x40, taken, target 0x100, `upd_pred_next_pc`=0x44.
   - Same cycle: `mispredict`=1, `redirect_pc`=0x100.
   - Next cycle, lookup 0x40: hit=1, taken=1, `pred_next_pc`=0x100; `mispred_cnt`=1.
3. Two not-taken updates at 0x40 → counter goes 2→1→0 and lookup gives `pred_next_pc`=0x44. One more taken update → counter 1, still predicts 0x44. Four taken updates → counter saturates at 3.
4. Alias: taken update at 0x80 (index 0, tag 2) with target 0x200 → lookup 0x40 misses; lookup 0x80 gives 0x200 with counter 2.
5. Same-cycle hazard: lookup 0x40 while updating 0x40 → lookup shows the old values; the new values appear the next cycle. Correct prediction (`upd_pred_next_pc` equals actual) → `mispredict`=0 and only `branch_cnt` increments.
6. `flush` together with `upd_en` → all lookups miss afterwards and `branch_cnt` still increments. Assert `rst` mid-sequence → all outputs return to reset values. Preload the counters near all-ones → statistics saturate and do not wrap.
